viterbi_acs_sched: RTL and testbench
====================================

# viterbi_acs_sched

Serial add-compare-select scheduler for the rate-1/2, K=3 (4-state) Viterbi decoder. It time-multiplexes a single branch-metric unit (BMU) across all 8 trellis branches of each received symbol and holds the 4 path metrics. For every symbol it emits one 4-bit survivor word plus the best state and its metric to the downstream traceback block.

## Interface

Parameters:
- `PM_W`, default 8: path-metric width in bits (≥4).
- `INIT_PM`, default 8: initial metric for states 1..3 at reset and at `frame_start`. State 0 starts at 0.

Ports:
- `clk`  in  1  rising-edge clock; the block uses one clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `frame_start`  in  1  single-cycle pulse that re-initialises the path metrics; sampled in IDLE only.
- `sym_valid`  in  1  received symbol valid.
- `sym_ready`  out  1  block can accept a symbol.
- `sym_code`  in  2  received code pair.
- `bmu_state`  out  2  current-state select driven to the BMU.
- `bmu_input`  out  1  hypothesised input bit driven to the BMU.
- `bmu_rec`  out  2  latched received code driven to the BMU.
- `bmu_dist`  in  3  Hamming distance returned combinationally by the BMU (0..2).
- `surv_valid`  out  1  one-cycle pulse: survivor outputs are valid.
- `surv_bits`  out  4  bit n is the survivor select for next-state n (0 = predecessor {n[0],0}, 1 = {n[0],1}).
- `best_state`  out  2  argmin of the updated metrics; the lowest index wins a tie.
- `best_metric`  out  PM_W  minimum updated metric, taken before normalisation.

## Operation

- Trellis: state = {u[-1], u[-2]}, next = {in, state[1]}. The predecessors of next-state n are {n[0],0} and {n[0],1}, both with input n[1].
- FSM states: IDLE, EVAL, UPD.
- IDLE:
  - `sym_ready` = 1 when `frame_start` = 0.
  - If `frame_start` = 1: pm = {0, INIT_PM, INIT_PM, INIT_PM}; no symbol is accepted that cycle.
  - If `sym_valid` && `sym_ready`: latch `sym_code`, clear the 3-bit counter k, go to EVAL.
- EVAL runs 8 cycles, k = 0..7. Let n = k[2:1] and b = k[0]:
  - Drive `bmu_state` = {n[0],b}, `bmu_input` = n[1], `bmu_rec` = latched code.
  - Compute cand = pm[bmu_state] + `bmu_dist`, saturating at 2^PM_W−1.
  - When b = 0: hold cand.
  - When b = 1: the new metric for n is the smaller of the two candidates, and `surv_bits[n]` is set to 1 only if cand(b=1) is strictly less. A tie selects predecessor 0.
  - New metrics go to a shadow bank. pm is unchanged during EVAL.
  - After k = 7, go to UPD.
- UPD runs 1 cycle:
  - Compute min and argmin of the shadow bank.
  - Commit the shadow bank to pm (normalised per Configuration).
  - Register `surv_bits`, `best_state`, `best_metric`, and set `surv_valid`.
  - Go to IDLE.
- Outside EVAL, the BMU drive outputs are 0.
- `sym_code` is sampled only at the handshake.

## Timing

- Reset values: `sym_ready` = 1 (IDLE), `surv_valid` = 0, `surv_bits` = 0, `best_state` = 0, `best_metric` = 0, BMU drives = 0, pm = {0, INIT_PM ×3}, FSM = IDLE.
- Handshake at edge E0. Cycles 1–8 are EVAL, cycle 9 is UPD, and `surv_valid` is high in cycle 10. In that same cycle `sym_ready` is 1 again.
- Throughput: 1 symbol per 10 cycles. `sym_ready` is 0 in cycles 1–9.
- `surv_valid` has no backpressure. The survivor outputs hold until the next UPD.
- `bmu_dist` is combinational from the BMU drives and is consumed in the same cycle.
- `rst_n` low in any state aborts the operation next edge: all reset values apply, and no `surv_valid` is produced for the aborted symbol.
- `frame_start` outside IDLE is ignored.

## Configuration

- `VITERBI_PM_NORM_EN` defined: in UPD, each committed metric = shadow − min(shadow). This keeps the best state at 0 and avoids growth. Saturation still applies to cand.
- Not defined: metrics are committed unchanged. They grow monotonically and saturate at 2^PM_W−1.

## Test plan

- Reset: hold `rst_n` = 0 for 2 cycles → `sym_ready` = 1, `surv_valid` = 0, internal pm = {0,8,8,8}.
- After init, send `sym_code` = 00:
  - BMU sequence over k = 0..7 is (state,in) = (0,0),(1,0),(2,0),(3,0),(0,1),(1,1),(2,1),(3,1).
  - Result pm = {0,9,2,9}, `surv_bits` = 4'b0000, `best_state` = 0, `best_metric` = 0.
  - `surv_valid` is asserted exactly 10 cycles after the handshake.
- After init, send 01:
  - With `VITERBI_PM_NORM_EN`: pm = {0,7,0,7}.
  - Without it: pm = {1,8,1,8}.
  - In both builds `surv_bits` = 4'b1000, `best_state` = 0, `best_metric` = 1.
- Error-free stream 11, 01, 00, 10 after init → `best_state` = 2, 1, 2, 3 and `best_metric` = 0 for every symbol.
- `sym_valid` held high with 3 symbols queued → exactly one acceptance every 10 cycles, and `sym_ready` is low for 9 cycles after each acceptance.
- Boundary cases:
  - Pulse `rst_n` low at EVAL k = 4 → no `surv_valid` follows, and pm returns to {0,8,8,8}.
  - `frame_start` and `sym_valid` in the same IDLE cycle → metrics are re-initialised and the symbol is accepted on the following cycle.

Source files
------------

// File: rtl/viterbi_acs_sched_if.sv
// Symbol, branch-metric-unit and survivor signals of viterbi_acs_sched.
// Symbol handshake: a symbol transfers on a rising edge where sym_valid && sym_ready; sym_code is sampled only then.
interface viterbi_acs_sched_if #(
  parameter int PM_W = 8
);
  logic            frame_start;
  logic            sym_valid;
  logic            sym_ready;
  logic [1:0]      sym_code;
  logic [1:0]      bmu_state;
  logic            bmu_input;
  logic [1:0]      bmu_rec;
  logic [2:0]      bmu_dist;
  logic            surv_valid;
  logic [3:0]      surv_bits;
  logic [1:0]      best_state;
  logic [PM_W-1:0] best_metric;

  modport master (
    output frame_start, sym_valid, sym_code, bmu_dist,
    input  sym_ready, bmu_state, bmu_input, bmu_rec,
    input  surv_valid, surv_bits, best_state, best_metric
  );

  modport slave (
    input  frame_start, sym_valid, sym_code, bmu_dist,
    output sym_ready, bmu_state, bmu_input, bmu_rec,
    output surv_valid, surv_bits, best_state, best_metric
  );
endinterface

// File: rtl/viterbi_acs_sched.sv
// Serial add-compare-select scheduler for a 4-state rate-1/2 Viterbi decoder.
// Define VITERBI_PM_NORM_EN to subtract the minimum from every metric at commit.
module viterbi_acs_sched #(
  parameter int PM_W    = 8,
  parameter int INIT_PM = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  viterbi_acs_sched_if.slave  bus,
  output logic [1:0]          o_dbg_state,
  output logic [4*PM_W-1:0]   o_dbg_pm
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    UPD  = 2'd2
  } state_t;

  localparam logic [PM_W-1:0] PM_MAX = '1;
  localparam logic [PM_W-1:0] PM_INI = PM_W'(INIT_PM);

  state_t          r_state;
  state_t          w_next;
  logic [2:0]      r_k;
  logic [1:0]      r_rec;
  logic [PM_W-1:0] r_pm     [4];
  logic [PM_W-1:0] r_shadow [4];
  logic [PM_W-1:0] r_cand0;
  logic [3:0]      r_surv_work;
  logic [3:0]      r_surv_bits;
  logic [1:0]      r_best_state;
  logic [PM_W-1:0] r_best_metric;
  logic            r_surv_valid;

  logic            w_accept;
  logic            w_init;
  logic [PM_W:0]   w_sum;
  logic [PM_W-1:0] w_cand;
  logic [PM_W-1:0] w_min;
  logic [1:0]      w_argmin;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // k = {n[1], n[0], b}: BMU state is {n[0], b} = k[1:0], hypothesised input is n[1] = k[2].
  always_comb begin
    w_next        = r_state;
    w_accept      = 1'b0;
    w_init        = 1'b0;
    bus.sym_ready = 1'b0;
    bus.bmu_state = 2'd0;
    bus.bmu_input = 1'b0;
    bus.bmu_rec   = 2'd0;
    case (r_state)
      IDLE: begin
        bus.sym_ready = !bus.frame_start;
        w_init        = bus.frame_start;
        w_accept      = bus.sym_valid && !bus.frame_start;
        if (w_accept) w_next = EVAL;
      end
      EVAL: begin
        bus.bmu_state = r_k[1:0];
        bus.bmu_input = r_k[2];
        bus.bmu_rec   = r_rec;
        if (r_k == 3'd7) w_next = UPD;
      end
      UPD:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_sum  = {1'b0, r_pm[r_k[1:0]]} + (PM_W+1)'(bus.bmu_dist);
    w_cand = w_sum[PM_W] ? PM_MAX : w_sum[PM_W-1:0];
  end

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    w_min    = r_shadow[0];
    w_argmin = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (r_shadow[i] < w_min) begin
        w_min    = r_shadow[i];
        w_argmin = 2'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_k           <= 3'd0;
      r_rec         <= 2'd0;
      r_cand0       <= '0;
      r_surv_work   <= 4'd0;
      r_surv_bits   <= 4'd0;
      r_best_state  <= 2'd0;
      r_best_metric <= '0;
      r_surv_valid  <= 1'b0;
      r_pm[0]       <= '0;
      for (int i = 1; i < 4; i++) r_pm[i] <= PM_INI;
      for (int i = 0; i < 4; i++) r_shadow[i] <= '0;
    end else begin
      r_surv_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_init) begin
            r_pm[0] <= '0;
            for (int i = 1; i < 4; i++) r_pm[i] <= PM_INI;
          end
          if (w_accept) begin
            r_rec <= bus.sym_code;
            r_k   <= 3'd0;
          end
        end
        EVAL: begin
          r_k <= r_k + 3'd1;
          if (!r_k[0]) begin
            r_cand0 <= w_cand;
          end else if (w_cand < r_cand0) begin
            r_shadow[r_k[2:1]]    <= w_cand;
            r_surv_work[r_k[2:1]] <= 1'b1;
          end else begin
            r_shadow[r_k[2:1]]    <= r_cand0;
            r_surv_work[r_k[2:1]] <= 1'b0;
          end
        end
        UPD: begin
          for (int i = 0; i < 4; i++) begin
`ifdef VITERBI_PM_NORM_EN
            r_pm[i] <= r_shadow[i] - w_min;
`else
            r_pm[i] <= r_shadow[i];
`endif
          end
          r_surv_bits   <= r_surv_work;
          r_best_state  <= w_argmin;
          r_best_metric <= w_min;
          r_surv_valid  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.surv_valid  = r_surv_valid;
  assign bus.surv_bits   = r_surv_bits;
  assign bus.best_state  = r_best_state;
  assign bus.best_metric = r_best_metric;
  assign o_dbg_state     = r_state;
  assign o_dbg_pm        = {r_pm[3], r_pm[2], r_pm[1], r_pm[0]};

endmodule

// File: tb/tb_viterbi_acs_sched.sv
// Self-checking bench for viterbi_acs_sched: vector table, corner sequences and a random stream
// compared against a trellis-level reference model; the BMU is modelled combinationally here.
module tb_viterbi_acs_sched;
  localparam int PM_W    = 5;
  localparam int INIT_PM = 8;
  localparam int PM_MAX  = (1 << PM_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0]        dbg_state;
  logic [4*PM_W-1:0] dbg_pm;

  viterbi_acs_sched_if #(.PM_W(PM_W)) vif ();

  viterbi_acs_sched #(.PM_W(PM_W), .INIT_PM(INIT_PM)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (vif),
    .o_dbg_state (dbg_state),
    .o_dbg_pm    (dbg_pm)
  );

  always #5 clk = ~clk;

  // Encoder g0 = 111, g1 = 101; the code pair is {c1, c0}.
  function automatic logic [1:0] enc(input logic [1:0] s, input logic u);
    logic c0, c1;
    c0 = u ^ s[1] ^ s[0];
    c1 = u ^ s[0];
    return {c1, c0};
  endfunction

  function automatic logic [2:0] hd(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return 3'(x[0]) + 3'(x[1]);
  endfunction

  assign vif.bmu_dist = hd(vif.bmu_rec, enc(vif.bmu_state, vif.bmu_input));

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: path metrics as plain integers.
  int         m_pm [4];
  logic [3:0] m_surv;
  int         m_bs;
  int         m_bm;

  function automatic void model_init();
    m_pm[0] = 0;
    for (int i = 1; i < 4; i++) m_pm[i] = INIT_PM;
  endfunction

  function automatic int sat(input int v);
    return (v > PM_MAX) ? PM_MAX : v;
  endfunction

  function automatic void model_step(input logic [1:0] code);
    int nw [4];
    int p0, c0, c1;
    logic u;
    for (int n = 0; n < 4; n++) begin
      p0 = (n % 2) * 2;
      u  = (n >= 2);
      c0 = sat(m_pm[p0]     + int'(hd(code, enc(2'(p0), u))));
      c1 = sat(m_pm[p0 + 1] + int'(hd(code, enc(2'(p0 + 1), u))));
      m_surv[n] = (c1 < c0);
      nw[n]     = (c1 < c0) ? c1 : c0;
    end
    m_bs = 0;
    m_bm = nw[0];
    for (int n = 1; n < 4; n++) if (nw[n] < m_bm) begin m_bm = nw[n]; m_bs = n; end
    for (int n = 0; n < 4; n++) begin
`ifdef VITERBI_PM_NORM_EN
      m_pm[n] = nw[n] - m_bm;
`else
      m_pm[n] = nw[n];
`endif
    end
  endfunction

  function automatic logic [4*PM_W-1:0] pack_pm();
    return {PM_W'(m_pm[3]), PM_W'(m_pm[2]), PM_W'(m_pm[1]), PM_W'(m_pm[0])};
  endfunction

  task automatic wait_ready();
    int cnt = 0;
    while (!vif.sym_ready && cnt < 40) begin @(negedge clk); cnt++; end
    check("ready_wait", 32'(vif.sym_ready), 32'd1);
  endtask

  task automatic pulse_init();
    wait_ready();
    vif.frame_start = 1'b1;
    @(negedge clk);
    vif.frame_start = 1'b0;
    model_init();
  endtask

  // Sends one symbol and checks timing, BMU drives and the survivor outputs against the model.
  task automatic send_symbol(input logic [1:0] code, input bit chk_bmu, input bit fs_same);
    logic [2:0] seq [8];
    int cnt, low;
    seq = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b001, 3'b011, 3'b101, 3'b111};
    wait_ready();
    vif.sym_valid = 1'b1;
    vif.sym_code  = code;
    if (fs_same) begin
      vif.frame_start = 1'b1;
      #1;
      check("fs_blocks_ready", 32'(vif.sym_ready), 32'd0);
      @(negedge clk);
      vif.frame_start = 1'b0;
      model_init();
      #1;
      check("fs_ready_next", 32'(vif.sym_ready), 32'd1);
    end
    @(negedge clk);
    vif.sym_valid = 1'b0;
    vif.sym_code  = 2'($urandom_range(0, 3));
    model_step(code);
    cnt = 1;
    low = 0;
    while (!vif.surv_valid && cnt < 20) begin
      if (!vif.sym_ready) low++;
      if (chk_bmu && cnt <= 8)
        check("bmu_seq", 32'({vif.bmu_state, vif.bmu_input, vif.bmu_rec}), 32'({seq[cnt-1], code}));
      if (cnt == 9)
        check("bmu_upd_zero", 32'({vif.bmu_state, vif.bmu_input, vif.bmu_rec}), 32'd0);
      @(negedge clk);
      cnt++;
    end
    check("surv_latency", 32'(cnt), 32'd10);
    check("ready_low_cycles", 32'(low), 32'd9);
    check("ready_with_surv", 32'(vif.sym_ready), 32'd1);
    check("surv_bits", 32'(vif.surv_bits), 32'(m_surv));
    check("best_state", 32'(vif.best_state), 32'(m_bs));
    check("best_metric", 32'(vif.best_metric), 32'(m_bm));
    check("pm", 32'(dbg_pm), 32'(pack_pm()));
    @(negedge clk);
    check("surv_pulse_one", 32'(vif.surv_valid), 32'd0);
  endtask

  typedef struct {
    bit                init;
    logic [1:0]        sym;
    bit                chk_pm;
    logic [4*PM_W-1:0] exp_pm;
    bit                chk_surv;
    logic [3:0]        exp_surv;
    logic [1:0]        exp_bs;
    logic [PM_W-1:0]   exp_bm;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, cyc, last, low, cnt;
    bit seen;
    logic [1:0] bq [3];

    tbl[0] = '{1'b1, 2'b00, 1'b1, {5'd9, 5'd2, 5'd9, 5'd0}, 1'b1, 4'b0000, 2'd0, 5'd0};
`ifdef VITERBI_PM_NORM_EN
    tbl[1] = '{1'b1, 2'b01, 1'b1, {5'd7, 5'd0, 5'd7, 5'd0}, 1'b1, 4'b1000, 2'd0, 5'd1};
`else
    tbl[1] = '{1'b1, 2'b01, 1'b1, {5'd8, 5'd1, 5'd8, 5'd1}, 1'b1, 4'b1000, 2'd0, 5'd1};
`endif
    tbl[2] = '{1'b1, 2'b11, 1'b0, '0, 1'b0, 4'b0, 2'd2, 5'd0};
    tbl[3] = '{1'b0, 2'b01, 1'b0, '0, 1'b0, 4'b0, 2'd1, 5'd0};
    tbl[4] = '{1'b0, 2'b00, 1'b0, '0, 1'b0, 4'b0, 2'd2, 5'd0};
    tbl[5] = '{1'b0, 2'b10, 1'b0, '0, 1'b0, 4'b0, 2'd3, 5'd0};

    // Clock / reset
    vif.frame_start = 1'b0;
    vif.sym_valid   = 1'b0;
    vif.sym_code    = 2'b00;
    rst_n           = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_init();
    check("rst_ready", 32'(vif.sym_ready), 32'd1);
    check("rst_surv_valid", 32'(vif.surv_valid), 32'd0);
    check("rst_outputs", 32'({vif.surv_bits, vif.best_state, vif.best_metric}), 32'd0);
    check("rst_bmu", 32'({vif.bmu_state, vif.bmu_input, vif.bmu_rec}), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_pm", 32'(dbg_pm), 32'({5'd8, 5'd8, 5'd8, 5'd0}));

    // Vector table
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].init) pulse_init();
      send_symbol(tbl[i].sym, (i == 0), 1'b0);
      check($sformatf("tbl%0d_best_state", i), 32'(vif.best_state), 32'(tbl[i].exp_bs));
      check($sformatf("tbl%0d_best_metric", i), 32'(vif.best_metric), 32'(tbl[i].exp_bm));
      if (tbl[i].chk_surv) check($sformatf("tbl%0d_surv", i), 32'(vif.surv_bits), 32'(tbl[i].exp_surv));
      if (tbl[i].chk_pm)   check($sformatf("tbl%0d_pm", i), 32'(dbg_pm), 32'(tbl[i].exp_pm));
    end

    // Reset during EVAL k = 4 aborts the symbol
    wait_ready();
    vif.sym_valid = 1'b1;
    vif.sym_code  = 2'b10;
    @(negedge clk);
    vif.sym_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_at_k4", 32'({vif.bmu_state, vif.bmu_input}), 32'b001);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_init();
    check("abort_ready", 32'(vif.sym_ready), 32'd1);
    seen = 1'b0;
    for (int c = 0; c < 15; c++) begin
      if (vif.surv_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("abort_no_surv", 32'(seen), 32'd0);
    check("abort_pm", 32'(dbg_pm), 32'({5'd8, 5'd8, 5'd8, 5'd0}));
    check("abort_outputs", 32'({vif.surv_bits, vif.best_state, vif.best_metric}), 32'd0);

    // Random stream against the model
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) pulse_init();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_symbol(2'($urandom_range(0, 3)), 1'b0, 1'b0);
    end

    // frame_start and sym_valid in the same IDLE cycle
    send_symbol(2'b01, 1'b0, 1'b0);
    send_symbol(2'b11, 1'b0, 1'b1);

    // Back-to-back symbols with sym_valid held high
    bq = '{2'b01, 2'b10, 2'b11};
    wait_ready();
    vif.sym_code  = bq[0];
    vif.sym_valid = 1'b1;
    acc = 0; cyc = 0; last = 0; low = 0;
    while (acc < 3 && cyc < 100) begin
      if (vif.sym_ready) begin
        if (acc > 0) begin
          check("b2b_gap", 32'(cyc - last), 32'd10);
          check("b2b_low", 32'(low), 32'd9);
        end
        model_step(bq[acc]);
        last = cyc;
        low  = 0;
        acc++;
        @(negedge clk);
        cyc++;
        if (acc < 3) vif.sym_code = bq[acc];
        else         vif.sym_valid = 1'b0;
      end else begin
        low++;
        @(negedge clk);
        cyc++;
      end
    end
    check("b2b_accepts", 32'(acc), 32'd3);
    cnt = 0;
    while (!vif.surv_valid && cnt < 20) begin @(negedge clk); cnt++; end
    check("b2b_done", 32'(vif.surv_valid), 32'd1);
    check("b2b_best_state", 32'(vif.best_state), 32'(m_bs));
    check("b2b_best_metric", 32'(vif.best_metric), 32'(m_bm));
    check("b2b_pm", 32'(dbg_pm), 32'(pack_pm()));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
